// File: rtl/cntl_mc_xlen.sv
// Multi-cycle RV32I/RV64I control unit. A Moore FSM sequences fetch,
// decode, execute, memory and write-back over a variable-latency memory
// port, with a bus timeout and a sticky trap state.
module cntl_mc_xlen #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_i,
  input  logic            bcond_i,
  input  logic            mem_ready_i,
  output logic [3:0]      state_o,
  output logic [XLEN-1:0] imm_o,
  output logic            pc_we_o,
  output logic            ir_we_o,
  output logic            mdr_we_o,
  output logic            rf_we_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            mem_addr_sel_o,
  output logic [1:0]      mem_size_o,
  output logic            mem_unsigned_o,
  output logic [1:0]      op1_sel_o,
  output logic [1:0]      op2_sel_o,
  output logic [1:0]      wb_sel_o,
  output logic [4:0]      alu_ctrl_o,
  output logic            illegal_o,
  output logic            bus_err_o
);

  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC   = 4'd2,
                         S_WB     = 4'd3,  S_PC_INC = 4'd4,  S_ADDR   = 4'd5,
                         S_MEM_RD = 4'd6,  S_MEM_WR = 4'd7,  S_BR_CMP = 4'd8,
                         S_BR_TGT = 4'd9,  S_JUMP   = 4'd10, S_TRAP   = 4'd11;

  localparam logic [6:0] OP_R  = 7'b0110011, OP_I   = 7'b0010011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_FENCE = 7'b0001111;

  // Counter must hold TIMEOUT itself; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [3:0]    state_q, state_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       wait_st, to_hit, dec_ill;
  logic [31:0] imm32;
  logic       b3_r, b3_i;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // The trap fires on the wait cycle that would bring the count to TIMEOUT;
  // a ready in that same cycle takes priority.
  assign to_hit  = (TIMEOUT != 0) && wait_st && !mem_ready_i &&
                   (cnt_q == CW'(TIMEOUT - 1));

  assign b3_r = (f3 == 3'b010 || f3 == 3'b011) ? 1'b1 : instr_i[30];
  assign b3_i = (f3 == 3'b010 || f3 == 3'b011) ? 1'b1 :
                (f3 == 3'b101) ? instr_i[30] : 1'b0;

  // Immediate assembly per format, sign-extended from bit 31 to XLEN.
  always_comb begin
    imm32 = '0;
    case (opc)
      OP_I, OP_LD, OP_JALR: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      OP_ST:                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OP_BR:                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                     instr_i[30:25], instr_i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:     imm32 = {instr_i[31:12], 12'b0};
      OP_JAL:               imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                     instr_i[20], instr_i[30:21], 1'b0};
      default:              imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

  // Next-state selection and trap-cause detection.
  always_comb begin
    state_d = state_q;
    dec_ill = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE; else if (to_hit) state_d = S_TRAP;
      S_DECODE: begin
        case (opc)
          OP_R, OP_I, OP_LUI, OP_AUIPC: state_d = S_EXEC;
          OP_LD, OP_ST:                 state_d = S_ADDR;
          OP_BR:                        state_d = S_BR_CMP;
          OP_JAL, OP_JALR:              state_d = S_JUMP;
          OP_FENCE:                     state_d = S_PC_INC;
          default: begin
            state_d = S_TRAP;
            dec_ill = 1'b1;
          end
        endcase
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_PC_INC;
      S_PC_INC: state_d = S_FETCH;
      S_ADDR:   state_d = (opc == OP_ST) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready_i) state_d = S_WB; else if (to_hit) state_d = S_TRAP;
      S_MEM_WR: if (mem_ready_i) state_d = S_PC_INC; else if (to_hit) state_d = S_TRAP;
      S_BR_CMP: state_d = bcond_i ? S_BR_TGT : S_PC_INC;
      S_BR_TGT: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  assign illegal_d = illegal_q | dec_ill;
  assign bus_err_d = bus_err_q | to_hit;
  // Any cycle outside a waiting memory state clears the count, so entry starts at 0.
  assign cnt_d     = (wait_st && !mem_ready_i) ? cnt_q + 1'b1 : '0;

  // State, sticky trap causes and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state_o        = state_q;
  assign illegal_o      = illegal_q;
  assign bus_err_o      = bus_err_q;
  assign mem_size_o     = f3[1:0];
  assign mem_unsigned_o = f3[2];

  // Moore datapath controls; enables are suppressed while reset is held.
  always_comb begin
    pc_we_o = 1'b0; ir_we_o = 1'b0; mdr_we_o = 1'b0; rf_we_o = 1'b0;
    mem_req_o = 1'b0; mem_we_o = 1'b0; mem_addr_sel_o = 1'b0;
    op1_sel_o = 2'd0; op2_sel_o = 2'd0; wb_sel_o = 2'd0; alu_ctrl_o = 5'd0;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ready_i;
      end
      S_EXEC: begin
        case (opc)
          OP_R:     alu_ctrl_o = {1'b0, b3_r, f3};
          OP_I:     begin op2_sel_o = 2'd1; alu_ctrl_o = {1'b0, b3_i, f3}; end
          OP_LUI:   begin op1_sel_o = 2'd2; op2_sel_o = 2'd1; end
          OP_AUIPC: begin op1_sel_o = 2'd1; op2_sel_o = 2'd1; end
          default:  ;
        endcase
      end
      S_WB: begin
        rf_we_o  = 1'b1;
        wb_sel_o = (opc == OP_LD) ? 2'd1 : 2'd0;
      end
      S_PC_INC: begin
        pc_we_o = 1'b1; op1_sel_o = 2'd1; op2_sel_o = 2'd2;
      end
      S_ADDR:   op2_sel_o = 2'd1;
      S_MEM_RD: begin
        mem_req_o = 1'b1; mem_addr_sel_o = 1'b1; mdr_we_o = mem_ready_i;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1; mem_we_o = 1'b1; mem_addr_sel_o = 1'b1;
      end
      S_BR_CMP: alu_ctrl_o = {2'b10, f3};
      S_BR_TGT: begin
        pc_we_o = 1'b1; op1_sel_o = 2'd1; op2_sel_o = 2'd1;
      end
      S_JUMP: begin
        // JAL targets PC+imm, JALR rs1+imm; link value is PC+4.
        rf_we_o = 1'b1; pc_we_o = 1'b1; wb_sel_o = 2'd2;
        op1_sel_o = (opc == OP_JAL) ? 2'd1 : 2'd0;
        op2_sel_o = 2'd1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_we_o = 1'b0; ir_we_o = 1'b0; mdr_we_o = 1'b0; rf_we_o = 1'b0;
      mem_req_o = 1'b0; mem_we_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_cntl_mc_xlen.sv
// Scoreboard bench for cntl_mc_xlen: two instances share stimulus,
// A (XLEN=32, TIMEOUT=16) and B (XLEN=64, TIMEOUT=4).
module tb_cntl_mc_xlen;

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_WB = 3, S_PC_INC = 4,
                 S_ADDR = 5, S_MEM_RD = 6, S_MEM_WR = 7, S_BR_CMP = 8,
                 S_BR_TGT = 9, S_JUMP = 10, S_TRAP = 11;

  logic        clk = 1'b0;
  logic        rst, bcond, mem_ready;
  logic [31:0] instr;

  logic [3:0]  a_state, b_state;
  logic [31:0] a_imm;
  logic [63:0] b_imm;
  logic a_pc_we, a_ir_we, a_mdr_we, a_rf_we, a_req, a_we, a_asel, a_uns, a_ill, a_be;
  logic b_pc_we, b_ir_we, b_mdr_we, b_rf_we, b_req, b_we, b_asel, b_uns, b_ill, b_be;
  logic [1:0] a_size, a_op1, a_op2, a_wb, b_size, b_op1, b_op2, b_wb;
  logic [4:0] a_alu, b_alu;
  logic [22:0] a_ctl, b_ctl;

  always #5 clk = ~clk;

  cntl_mc_xlen #(.XLEN(32), .TIMEOUT(16)) u_a (
    .clk(clk), .rst(rst), .instr_i(instr), .bcond_i(bcond), .mem_ready_i(mem_ready),
    .state_o(a_state), .imm_o(a_imm), .pc_we_o(a_pc_we), .ir_we_o(a_ir_we),
    .mdr_we_o(a_mdr_we), .rf_we_o(a_rf_we), .mem_req_o(a_req), .mem_we_o(a_we),
    .mem_addr_sel_o(a_asel), .mem_size_o(a_size), .mem_unsigned_o(a_uns),
    .op1_sel_o(a_op1), .op2_sel_o(a_op2), .wb_sel_o(a_wb), .alu_ctrl_o(a_alu),
    .illegal_o(a_ill), .bus_err_o(a_be));

  cntl_mc_xlen #(.XLEN(64), .TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst), .instr_i(instr), .bcond_i(bcond), .mem_ready_i(mem_ready),
    .state_o(b_state), .imm_o(b_imm), .pc_we_o(b_pc_we), .ir_we_o(b_ir_we),
    .mdr_we_o(b_mdr_we), .rf_we_o(b_rf_we), .mem_req_o(b_req), .mem_we_o(b_we),
    .mem_addr_sel_o(b_asel), .mem_size_o(b_size), .mem_unsigned_o(b_uns),
    .op1_sel_o(b_op1), .op2_sel_o(b_op2), .wb_sel_o(b_wb), .alu_ctrl_o(b_alu),
    .illegal_o(b_ill), .bus_err_o(b_be));

  assign a_ctl = {a_pc_we, a_ir_we, a_mdr_we, a_rf_we, a_req, a_we, a_asel,
                  a_op1, a_op2, a_wb, a_alu, a_size, a_uns, a_ill, a_be};
  assign b_ctl = {b_pc_we, b_ir_we, b_mdr_we, b_rf_we, b_req, b_we, b_asel,
                  b_op1, b_op2, b_wb, b_alu, b_size, b_uns, b_ill, b_be};

  typedef struct {
    string       tag;
    logic [3:0]  sa;
    logic [22:0] ca;
    logic [3:0]  sb;
    logic [22:0] cb;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] cur_instr = '0;
  logic [31:0] cur_imm = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected control vector, in the same bit order as a_ctl/b_ctl.
  function automatic logic [22:0] cv(input int pc, ir, mdr, rf, req, we, as,
                                     o1, o2, wb, alu, ill, be);
    return {1'(pc), 1'(ir), 1'(mdr), 1'(rf), 1'(req), 1'(we), 1'(as),
            2'(o1), 2'(o2), 2'(wb), 5'(alu), cur_instr[13:12], cur_instr[14],
            1'(ill), 1'(be)};
  endfunction

  // Compare against the scoreboard entry for the current cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, ":st_a"},  64'(a_state), 64'(e.sa));
      chk({e.tag, ":ctl_a"}, 64'(a_ctl),   64'(e.ca));
      chk({e.tag, ":imm_a"}, 64'(a_imm),   64'(e.imm));
      chk({e.tag, ":st_b"},  64'(b_state), 64'(e.sb));
      chk({e.tag, ":ctl_b"}, 64'(b_ctl),   64'(e.cb));
      chk({e.tag, ":imm_b"}, b_imm,        {{32{e.imm[31]}}, e.imm});
    end
  end

  task automatic drive(input string t, input int rdy, input int bc,
                       input int sa, input logic [22:0] ca, input int sb, input logic [22:0] cb);
    exp_t e;
    mem_ready = 1'(rdy);
    bcond     = 1'(bc);
    e.tag = t; e.sa = 4'(sa); e.ca = ca; e.sb = 4'(sb); e.cb = cb; e.imm = cur_imm;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic d1(input string t, input int rdy, input int bc, input int s, input logic [22:0] c);
    drive(t, rdy, bc, s, c, s, c);
  endtask

  task automatic set_instr(input logic [31:0] i, input logic [31:0] im);
    instr = i; cur_instr = i; cur_imm = im;
  endtask

  task automatic s_fetch(input string t, input int rdy);
    d1(t, rdy, 0, S_FETCH, cv(0, rdy, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic s_dec(input string t);
    d1(t, 0, 0, S_DECODE, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic s_pcinc(input string t);
    d1(t, 1, 0, S_PC_INC, cv(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
  endtask

  // Full R/I/U sequence with zero wait states.
  task automatic alu_op(input string t, input logic [31:0] i, input logic [31:0] im,
                        input int o1, input int o2, input int alu);
    set_instr(i, im);
    s_fetch({t, "_f"}, 1);
    s_dec({t, "_d"});
    d1({t, "_ex"}, 1, 0, S_EXEC, cv(0, 0, 0, 0, 0, 0, 0, o1, o2, 0, alu, 0, 0));
    d1({t, "_wb"}, 1, 0, S_WB,   cv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s_pcinc({t, "_pc"});
  endtask

  initial begin
    rst = 1'b1; instr = '0; bcond = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    d1("rst0", 0, 0, S_FETCH, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    d1("rst1", 1, 0, S_FETCH, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    alu_op("add",   32'h002081B3, 32'h0,        0, 0, 'b00000);
    alu_op("sub",   32'h402081B3, 32'h0,        0, 0, 'b01000);
    alu_op("slt",   32'h0020A1B3, 32'h0,        0, 0, 'b01010);
    alu_op("sltiu", 32'hFFF13093, 32'hFFFFFFFF, 0, 1, 'b01011);
    alu_op("srai",  32'h40315093, 32'h00000403, 0, 1, 'b01101);
    alu_op("lui",   32'h123450B7, 32'h12345000, 2, 1, 'b00000);
    alu_op("auipc", 32'hFFFFF097, 32'hFFFFF000, 1, 1, 'b00000);

    // LW x5,8(x1) with three wait states in MEM_RD
    set_instr(32'h0080A283, 32'h8);
    s_fetch("lw_f", 1);
    s_dec("lw_d");
    d1("lw_addr", 1, 0, S_ADDR, cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      d1("lw_wait", 0, 0, S_MEM_RD, cv(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    d1("lw_rd", 1, 0, S_MEM_RD, cv(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    d1("lw_wb", 1, 0, S_WB,     cv(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    s_pcinc("lw_pc");

    // SW x2,12(x1) with one wait state
    set_instr(32'h0020A623, 32'hC);
    s_fetch("sw_f", 1);
    s_dec("sw_d");
    d1("sw_addr", 1, 0, S_ADDR,   cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    d1("sw_wait", 0, 0, S_MEM_WR, cv(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    d1("sw_wr",   1, 0, S_MEM_WR, cv(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    s_pcinc("sw_pc");

    // BEQ -8, taken then not taken
    set_instr(32'hFE000CE3, 32'hFFFFFFF8);
    s_fetch("beqt_f", 1);
    s_dec("beqt_d");
    d1("beqt_cmp", 1, 1, S_BR_CMP, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b10000, 0, 0));
    d1("beqt_tgt", 1, 0, S_BR_TGT, cv(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    s_fetch("beqn_f", 1);
    s_dec("beqn_d");
    d1("beqn_cmp", 1, 0, S_BR_CMP, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b10000, 0, 0));
    s_pcinc("beqn_pc");

    // JALR x1,0(x1) and JAL x0,-4
    set_instr(32'h000080E7, 32'h0);
    s_fetch("jalr_f", 1);
    s_dec("jalr_d");
    d1("jalr_j", 1, 0, S_JUMP, cv(1, 0, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    set_instr(32'hFFDFF06F, 32'hFFFFFFFC);
    s_fetch("jal_f", 1);
    s_dec("jal_d");
    d1("jal_j", 1, 0, S_JUMP, cv(1, 0, 0, 1, 0, 0, 0, 1, 1, 2, 0, 0, 0));

    // FENCE: straight to PC_INC
    set_instr(32'h0000000F, 32'h0);
    s_fetch("fence_f", 1);
    s_dec("fence_d");
    s_pcinc("fence_pc");

    // ECALL is illegal here: sticky trap until reset
    set_instr(32'h00000073, 32'h0);
    s_fetch("ecall_f", 1);
    s_dec("ecall_d");
    for (int k = 0; k < 20; k++)
      d1("ecall_trap", 1, 1, S_TRAP, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    rst = 1'b1;
    d1("ecall_rsttrap", 1, 0, S_TRAP,  cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    d1("ecall_rst",     1, 0, S_FETCH, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // Fetch timeout: B (TIMEOUT=4) traps after 4 wait cycles, A keeps waiting
    set_instr(32'h0000000F, 32'h0);
    for (int k = 0; k < 4; k++) s_fetch("to_wait", 0);
    for (int k = 0; k < 3; k++)
      drive("to_trap", 0, 0, S_FETCH, cv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
            S_TRAP, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst = 1'b1;
    drive("to_rsttrap", 0, 0, S_FETCH, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
          S_TRAP, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    d1("to_rst", 0, 0, S_FETCH, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // Ready arriving on the 4th cycle wins over the timeout
    for (int k = 0; k < 3; k++) s_fetch("tor_wait", 0);
    s_fetch("tor_rdy", 1);
    s_dec("tor_d");
    s_pcinc("tor_pc");
    s_fetch("tor_next", 1);

    @(posedge clk); #1;
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cntl_mc_xlen.md
# cntl_mc_xlen

Parametrised multi-cycle RV32I/RV64I control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It sits between the instruction register/ALU/register file and a variable-latency unified memory port. It adds the following:
- XLEN-wide, fully extended immediates.
- A `mem_req`/`mem_ready` handshake with wait states.
- A configurable bus timeout.
- A sticky trap state for illegal opcodes and bus errors.

## Interface
- XLEN, 32, datapath width (32 or 64); width of `imm`.
- TIMEOUT, 16, max consecutive `mem_ready`-low cycles in a wait state; 0 disables the timeout.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  IR contents; stable from DECODE until the next FETCH.
- bcond  in  1  ALU compare result; sampled only in BR_CMP.
- mem_ready  in  1  memory completes the current request this cycle.
- state  out  4  current state encoding.
- imm  out  XLEN  immediate, extended per format.
- pc_we, ir_we, mdr_we, rf_we  out  1 each  register write enables.
- mem_req, mem_we  out  1 each  memory request, memory write.
- mem_addr_sel  out  1  0 = PC, 1 = ALUOut.
- mem_size  out  2  funct3[1:0].
- mem_unsigned  out  1  funct3[2].
- op1_sel  out  2  0 = rs1, 1 = PC, 2 = zero.
- op2_sel  out  2  0 = rs2, 1 = imm, 2 = constant 4.
- wb_sel  out  2  0 = ALU, 1 = MDR, 2 = PC+4.
- alu_ctrl  out  5  {branch, sub/arith, funct3}.
- illegal, bus_err  out  1 each  trap causes.

## Operation

**State encoding:** FETCH 0, DECODE 1, EXEC 2, WB 3, PC_INC 4, ADDR 5, MEM_RD 6, MEM_WR 7, BR_CMP 8, BR_TGT 9, JUMP 10, TRAP 11.

**Outputs:** combinational from the state register and `instr`. Unlisted enables are 0 and unlisted selects are 0.

**Per-state behaviour:**
- FETCH: `mem_req=1`, `mem_addr_sel=0`, `ir_we=mem_ready`. Goes to DECODE on `mem_ready`; otherwise waits.
- DECODE: no enables. The next state is selected by `instr[6:0]`:
  - 0110011 / 0010011 / 0110111 / 0010111 → EXEC.
  - 0000011 / 0100011 → ADDR.
  - 1100011 → BR_CMP.
  - 1101111 / 1100111 → JUMP.
  - 0001111 (FENCE) → PC_INC.
  - Any other opcode, including `instr[1:0]≠11`, → TRAP with `illegal` set.
- EXEC: operand selects by opcode:
  - R-type: rs1, rs2.
  - I-type: rs1, imm.
  - LUI: zero, imm.
  - AUIPC: PC, imm.
  - Next state: WB.
- WB: `rf_we=1`; `wb_sel` = MDR for loads, otherwise ALU. Next state: PC_INC.
- PC_INC: PC, 4, add, `pc_we=1`. Next state: FETCH.
- ADDR: rs1, imm, add. Next state: MEM_RD for loads, MEM_WR for stores.
- MEM_RD: `mem_req=1`, `mem_addr_sel=1`, `mdr_we=mem_ready`. Goes to WB on `mem_ready`.
- MEM_WR: `mem_req=1`, `mem_we=1`, `mem_addr_sel=1`. Goes to PC_INC on `mem_ready`.
- BR_CMP: rs1, rs2. Goes to BR_TGT if `bcond`, else PC_INC.
- BR_TGT: PC, imm, add, `pc_we=1`. Next state: FETCH.
- JUMP: single state.
  - `rf_we=1`, `wb_sel=2`, `pc_we=1`.
  - Operands: JAL uses PC, imm; JALR uses rs1, imm.
  - The datapath clears target bit 0.
  - A register-file read of the old rd is valid when rd=rs1.
  - Next state: FETCH.
- TRAP: all enables 0; cause outputs held. Exits only on `rst`.

**alu_ctrl encoding:**
- Add (ADDR, PC_INC, BR_TGT, JUMP, LUI, AUIPC): 00000.
- R-type: {0, instr[30], f3}.
- I-type: {0, b3, f3}, where b3 = 1 for f3 ∈ {010, 011}, b3 = instr[30] for f3 = 101, else 0.
- R-type with f3 ∈ {010, 011}: b3 forced to 1.
- Branch: {1, 0, f3}.

**imm:** always sign-extended from its top bit to XLEN.
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- SLTIU immediate is sign-extended, per the ISA.

**Timeout:**
- A counter clears on entry to FETCH, MEM_RD or MEM_WR.
- It increments each cycle `mem_ready=0` in those states.
- When it reaches TIMEOUT, the next state is TRAP and `bus_err` is set.
- If `mem_ready=1` in the same cycle the count reaches TIMEOUT, the ready wins and no trap occurs.
- Width: clog2(TIMEOUT+1).

## Timing
- **Reset:** on `rst` high at a clock edge, state becomes FETCH; `illegal`, `bus_err` and the counter become 0. While `rst=1`, every enable and `mem_req` is forced to 0. First request occurs the cycle after `rst` falls.
- **Latency, zero wait states:**
  - R/I/LUI/AUIPC: 5 cycles.
  - Load: 6 cycles.
  - Store: 5 cycles.
  - Branch (taken or not): 4 cycles.
  - JAL/JALR: 3 cycles.
  - FENCE: 3 cycles.
- Each `mem_ready`-low cycle adds one cycle.
- **Handshake:** `mem_req`, address select, `mem_we` and `mem_size` are held constant until the cycle `mem_ready=1`. `mem_ready` outside wait states is ignored.
- `illegal` and `bus_err` assert the cycle TRAP is entered and stay high until reset.

## Test plan
- ADD x3,x1,x2 (0x002081B3), `mem_ready` tied 1 → states 0,1,2,3,4,0; `rf_we` only in cycle 4; `alu_ctrl=00000`; `pc_we` cycle 5.
- LW with `mem_ready` low for 3 cycles in MEM_RD, TIMEOUT=16 → `mem_req`/`mem_addr_sel=1` held 4 cycles; `mdr_we` pulses once; 9 cycles total.
- BEQ offset −8 (0xFE000CE3): with `bcond=1` → BR_TGT, imm=0xFFFFFFF8, `alu_ctrl=10000`; with `bcond=0` → PC_INC.
- JALR x1,0(x1) → one JUMP cycle with `rf_we`, `pc_we`, `wb_sel=2`, `op1_sel=0`, all asserted together.
- instr 0x00000073 (ECALL) → TRAP, `illegal=1`, all enables 0 for 20 cycles; `rst` → FETCH, `illegal=0`.
- TIMEOUT=4, `mem_ready=0` in FETCH → TRAP with `bus_err=1` after 4 wait cycles; repeat with `mem_ready` on 4th cycle → DECODE, no trap.
